// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between gate_truth_checker and the 2-input gate
// it exercises. The checker side uses the master modport; the environment
// (gate instance plus whoever issues start) uses the slave modport.
interface gate_truth_checker_if;
  logic       start;
  logic       drv_a;
  logic       drv_b;
  logic       dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [3:0] observed;

  modport master (
    input  start,
    input  dut_y,
    output drv_a,
    output drv_b,
    output busy,
    output done,
    output pass,
    output fail_mask,
    output observed
  );

  modport slave (
    output start,
    output dut_y,
    input  drv_a,
    input  drv_b,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask,
    input  observed
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Sequential truth-table checker for a 2-input gate. Walks the gate inputs
// through 00, 01, 10, 11, waits SETTLE_CYCLES extra cycles per vector,
// samples the gate output and compares it against TRUTH (bit idx = expected
// Y for {A,B} = idx). All outputs come straight from flops.
module gate_truth_checker #(
  parameter logic [3:0]  TRUTH         = 4'b0001,
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_truth_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  // Counter reload value and the state entered after driving each vector.
  // With no settle time the very next edge is the sample edge.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam state_t     FIRST_STATE = (SETTLE_CYCLES == 32'd0) ? SAMPLE : SETTLE;

  // A sample mismatches unless it is exactly the expected level, so X or Z
  // on the gate output is always reported as a failure.
  function automatic logic sample_mismatch(input logic sample, input logic expected);
    return (sample !== expected);
  endfunction

  state_t     state_r;
  state_t     state_s;
  logic [1:0] idx_r;
  logic [1:0] idx_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_s;
  logic       drv_a_r;
  logic       drv_a_s;
  logic       drv_b_r;
  logic       drv_b_s;
  logic       busy_r;
  logic       busy_s;
  logic       done_r;
  logic       done_s;
  logic       pass_r;
  logic       pass_s;
  logic [3:0] fail_mask_r;
  logic [3:0] fail_mask_s;
  logic [3:0] observed_r;
  logic [3:0] observed_s;
  logic       sample_miss_s;

  // Next-state and next-value logic for the run sequencer.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    cnt_s         = cnt_r;
    drv_a_s       = drv_a_r;
    drv_b_s       = drv_b_r;
    busy_s        = busy_r;
    done_s        = 1'b0;
    pass_s        = pass_r;
    fail_mask_s   = fail_mask_r;
    observed_s    = observed_r;
    sample_miss_s = sample_mismatch(bus.dut_y, TRUTH[idx_r]);

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          // Accept a run: clear previous results and present vector 00.
          pass_s      = 1'b0;
          fail_mask_s = 4'b0000;
          observed_s  = 4'b0000;
          idx_s       = 2'd0;
          drv_a_s     = 1'b0;
          drv_b_s     = 1'b0;
          cnt_s       = SETTLE_LOAD;
          busy_s      = 1'b1;
          state_s     = FIRST_STATE;
        end else begin
          state_s = IDLE;
        end
      end

      SETTLE: begin
        // The edge that takes the count to zero is the last settle edge.
        // A zero count here cannot normally occur; treat it as settled
        // rather than letting the counter wrap.
        if (cnt_r <= 8'd1) begin
          cnt_s   = 8'd0;
          state_s = SAMPLE;
        end else begin
          cnt_s   = cnt_r - 8'd1;
          state_s = SETTLE;
        end
      end

      SAMPLE: begin
        observed_s[idx_r]  = bus.dut_y;
        fail_mask_s[idx_r] = sample_miss_s;
        if (idx_r != 2'd3) begin
          idx_s   = idx_r + 2'd1;
          drv_a_s = idx_s[1];
          drv_b_s = idx_s[0];
          cnt_s   = SETTLE_LOAD;
          state_s = FIRST_STATE;
        end else begin
          // Last vector sampled: park the gate inputs and report.
          idx_s   = 2'd0;
          cnt_s   = 8'd0;
          drv_a_s = 1'b0;
          drv_b_s = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (fail_mask_s == 4'b0000);
          state_s = IDLE;
        end
      end

      default: begin
        // Unreachable encoding: abandon any run and return to a safe idle.
        idx_s   = 2'd0;
        cnt_s   = 8'd0;
        drv_a_s = 1'b0;
        drv_b_s = 1'b0;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= 2'd0;
      cnt_r       <= 8'd0;
      drv_a_r     <= 1'b0;
      drv_b_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_mask_r <= 4'b0000;
      observed_r  <= 4'b0000;
    end else begin
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      drv_a_r     <= drv_a_s;
      drv_b_r     <= drv_b_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_mask_r <= fail_mask_s;
      observed_r  <= observed_s;
    end
  end

  assign bus.drv_a     = drv_a_r;
  assign bus.drv_b     = drv_b_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.fail_mask = fail_mask_r;
  assign bus.observed  = observed_r;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three checker instances (NOR S=0, NOR S=3,
// NAND S=0), each driving a behavioural gate with selectable lag or a stuck
// output. A cycle-count model predicts every output each cycle; directed
// literal checks pin the model.
module tb_gate_truth_checker;
  localparam int         N         = 3;
  localparam int         S_TAB [N] = '{0, 3, 0};
  localparam logic [3:0] T_TAB [N] = '{4'b0001, 4'b0001, 4'b0111};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] start_v;
  logic [N-1:0] y_v;
  logic [N-1:0] y_neg;
  int           lag_v   [N];
  bit           stuck_v [N];
  logic [7:0]   hist    [N];

  logic [1:0]   act_drv  [N];
  logic [N-1:0] act_busy;
  logic [N-1:0] act_done;
  logic [N-1:0] act_pass;
  logic [3:0]   act_fail [N];
  logic [3:0]   act_obs  [N];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e0     = 0;
  int dt     = 0;

  initial forever #5 clk = ~clk;

  gate_truth_checker_if bus0 ();
  gate_truth_checker_if bus1 ();
  gate_truth_checker_if bus2 ();

  gate_truth_checker #(.TRUTH(4'b0001), .SETTLE_CYCLES(0)) u_nor_s0 (.clk(clk), .rst(rst), .bus(bus0));
  gate_truth_checker #(.TRUTH(4'b0001), .SETTLE_CYCLES(3)) u_nor_s3 (.clk(clk), .rst(rst), .bus(bus1));
  gate_truth_checker #(.TRUTH(4'b0111), .SETTLE_CYCLES(0)) u_nand_s0 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.start = start_v[0];
  assign bus1.start = start_v[1];
  assign bus2.start = start_v[2];
  assign bus0.dut_y = y_v[0];
  assign bus1.dut_y = y_v[1];
  assign bus2.dut_y = y_v[2];

  assign act_drv[0] = {bus0.drv_a, bus0.drv_b};
  assign act_drv[1] = {bus1.drv_a, bus1.drv_b};
  assign act_drv[2] = {bus2.drv_a, bus2.drv_b};
  assign act_busy   = {bus2.busy, bus1.busy, bus0.busy};
  assign act_done   = {bus2.done, bus1.done, bus0.done};
  assign act_pass   = {bus2.pass, bus1.pass, bus0.pass};
  assign act_fail[0] = bus0.fail_mask;
  assign act_fail[1] = bus1.fail_mask;
  assign act_fail[2] = bus2.fail_mask;
  assign act_obs[0]  = bus0.observed;
  assign act_obs[1]  = bus1.observed;
  assign act_obs[2]  = bus2.observed;

  // Ideal gate: instance 2 is a NAND, the others NOR.
  function automatic logic ideal(input int i, input logic [1:0] d);
    if (i == 2) return ~(d[1] & d[0]);
    else        return ~(d[1] | d[0]);
  endfunction

  // Gate lag line: history of ideal outputs, one entry per clock.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) hist[i] <= 8'h00;
      else     hist[i] <= {hist[i][6:0], ideal(i, act_drv[i])};
    end
  end

  // Gate output seen by each checker.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (stuck_v[i])       y_v[i] = 1'b1;
      else if (lag_v[i] == 0) y_v[i] = ideal(i, act_drv[i]);
      else                  y_v[i] = hist[i][lag_v[i]-1];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) y_neg <= y_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is just a cycle age since the accept edge; every (S+1)
  // cycles one vector is sampled, vector index = age/(S+1).
  bit         m_run  [N];
  int         m_age  [N];
  logic [3:0] m_obs  [N];
  logic [3:0] m_fail [N];
  logic       m_pass [N];
  logic       m_done [N];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      int p;
      int a;
      int k;
      logic [3:0] f;
      if (rst) begin
        m_run[i]  <= 1'b0;
        m_age[i]  <= 0;
        m_obs[i]  <= 4'b0000;
        m_fail[i] <= 4'b0000;
        m_pass[i] <= 1'b0;
        m_done[i] <= 1'b0;
      end else begin
        p = S_TAB[i] + 1;
        m_done[i] <= 1'b0;
        if (m_run[i]) begin
          a = m_age[i] + 1;
          m_age[i] <= a;
          if (a % p == 0) begin
            k = a / p - 1;
            f = m_fail[i];
            f[k] = (y_neg[i] !== T_TAB[i][k]);
            m_obs[i][k] <= y_neg[i];
            m_fail[i]   <= f;
            if (k == 3) begin
              m_run[i]  <= 1'b0;
              m_done[i] <= 1'b1;
              m_pass[i] <= (f == 4'b0000);
            end
          end
        end else if (start_v[i]) begin
          m_run[i]  <= 1'b1;
          m_age[i]  <= 0;
          m_obs[i]  <= 4'b0000;
          m_fail[i] <= 4'b0000;
          m_pass[i] <= 1'b0;
        end
      end
    end
  end

  // Every cycle, every instance: all outputs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [12:0] a;
      logic [12:0] e;
      int p;
      p = S_TAB[i] + 1;
      a = {act_busy[i], act_done[i], act_pass[i], act_drv[i], act_fail[i], act_obs[i]};
      e = {m_run[i], m_done[i], m_pass[i], (m_run[i] ? 2'(m_age[i] / p) : 2'b00), m_fail[i], m_obs[i]};
      check($sformatf("model_i%0d busy,done,pass,drv,fail,obs", i), 32'(a), 32'(e));
    end
  end

  // Called at a negedge: start is high for exactly the next edge (E0).
  task automatic start_run(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    e0 = cyc;
  endtask

  // Wait (bounded) for done; dt = edges from E0 to the edge raising done.
  task automatic wait_done(input int i, input int limit);
    bit seen;
    seen = 1'b0;
    dt = -1;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      if (act_done[i]) begin
        seen = 1'b1;
        dt = cyc - e0;
      end
    end
    check($sformatf("done_seen_i%0d", i), 32'(seen), 32'd1);
  endtask

  initial begin
    logic [7:0] seq;
    int ndone;
    start_v = '0;
    for (int i = 0; i < N; i++) begin
      lag_v[i]   = 0;
      stuck_v[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({act_busy, act_done, act_pass, act_drv[0], act_drv[1], act_drv[2],
               act_fail[0], act_obs[0], act_fail[1], act_obs[1], act_fail[2], act_obs[2]}),
          32'd0);
    rst = 1'b0;
    @(negedge clk);

    // NOR, S=0, ideal gate
    start_run(0);
    seq = {6'd0, act_drv[0]};
    repeat (3) begin
      @(negedge clk);
      seq = {seq[5:0], act_drv[0]};
    end
    check("nor_drv_seq", 32'(seq), 32'h1B);
    wait_done(0, 20);
    check("nor_done_lat", dt, 4);
    check("nor_pass", 32'(act_pass[0]), 32'd1);
    check("nor_observed", 32'(act_obs[0]), 32'b0001);
    check("nor_fail_mask", 32'(act_fail[0]), 32'b0000);

    // NOR, S=0, output stuck at 1
    stuck_v[0] = 1'b1;
    @(negedge clk);
    start_run(0);
    wait_done(0, 20);
    check("stuck_observed", 32'(act_obs[0]), 32'b1111);
    check("stuck_fail_mask", 32'(act_fail[0]), 32'b1110);
    check("stuck_pass", 32'(act_pass[0]), 32'd0);
    stuck_v[0] = 1'b0;
    @(negedge clk);

    // NOR, S=3, gate settling in 4 cycles then in 5 cycles
    lag_v[1] = 3;
    @(negedge clk);
    start_run(1);
    wait_done(1, 40);
    check("lag4_done_lat", dt, 16);
    check("lag4_pass", 32'(act_pass[1]), 32'd1);
    lag_v[1] = 4;
    repeat (2) @(negedge clk);
    start_run(1);
    wait_done(1, 40);
    check("lag5_done_lat", dt, 16);
    check("lag5_pass", 32'(act_pass[1]), 32'd0);
    check("lag5_fail_mask", 32'(act_fail[1]), 32'b0010);
    check("lag5_observed", 32'(act_obs[1]), 32'b0011);

    // NAND with TRUTH 0111, then back-to-back start in the done cycle
    start_run(2);
    wait_done(2, 20);
    check("nand_pass", 32'(act_pass[2]), 32'd1);
    check("nand_observed", 32'(act_obs[2]), 32'b0111);
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    e0 = cyc;
    check("b2b_busy", 32'(act_busy[2]), 32'd1);
    check("b2b_done_low", 32'(act_done[2]), 32'd0);
    wait_done(2, 20);
    check("b2b_done_lat", dt, 4);
    check("b2b_pass", 32'(act_pass[2]), 32'd1);

    // Repeated start while busy must not disturb the run
    start_v[0] = 1'b1;
    @(negedge clk);
    e0 = cyc;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 20);
    check("busy_start_done_lat", dt, 4);
    check("busy_start_pass", 32'(act_pass[0]), 32'd1);

    // Reset two edges into a run
    start_run(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("busy_before_rst", 32'(act_busy[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_outputs",
          32'({act_busy[0], act_done[0], act_pass[0], act_drv[0], act_fail[0], act_obs[0]}),
          32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (act_done[0]) ndone++;
    end
    check("no_done_after_rst", ndone, 0);
    start_run(0);
    wait_done(0, 20);
    check("post_rst_done_lat", dt, 4);
    check("post_rst_pass", 32'(act_pass[0]), 32'd1);
    check("post_rst_observed", 32'(act_obs[0]), 32'b0001);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
